// File: rtl/logic_gate_pkg.sv
// Shared op encodings and bitwise helpers for the pipelined gate library.
// Helpers work on a fixed-width word; callers zero-extend and pass a width mask.
package logic_gate_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned MAX_W = 64;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_PASS = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t width_mask(input int unsigned w);
    word_t m;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      m[i] = (i < w);
    end
    return m;
  endfunction

  function automatic word_t apply_op(input op_e op, input word_t a, input word_t b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      OP_XNOR: return ~(a ^ b);
      OP_PASS: return a;
      default: return ~a;
    endcase
  endfunction

  // Bits outside the mask are forced to the identity of each reduction.
  function automatic logic reduce_op(input op_e op, input word_t r, input word_t mask);
    case (op)
      OP_AND, OP_NAND: return &(r | ~mask);
      OP_OR, OP_NOR:   return |(r & mask);
      default:         return ^(r & mask);
    endcase
  endfunction

endpackage

// File: rtl/logic_gate_stage.sv
// One {valid, data} pipeline register; accepts a new beat whenever it is
// empty or its content is leaving this cycle.
module logic_gate_stage #(
  parameter int unsigned DW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid_i,
  input  logic [DW-1:0] up_data_i,
  input  logic          down_ready_i,
  output logic          ready_c_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  assign ready_c_o = !valid_q || down_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_c_o) begin
      valid_d = up_valid_i;
      if (up_valid_i) begin
        data_d = up_data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined multi-function bitwise unit with valid/ready on both sides and an
// accumulator that chains each accepted result into the next operation.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   z,
  output logic [WIDTH-1:0] acc
);

  localparam int unsigned ZW = WIDTH + 1;

  logic [WIDTH-1:0] opb;
  word_t            res_full;
  logic [WIDTH-1:0] res;
  logic             red;
  logic             accept;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             stg_valid [STAGES];
  logic [ZW-1:0]    stg_data  [STAGES];
  logic             stg_ready [STAGES];

  // Seed (in_clr) overrides accumulate so a chain can restart from b.
  assign opb      = (in_acc && !in_clr) ? acc_q : b;
  assign res_full = apply_op(op_e'(in_op), MAX_W'(a), MAX_W'(opb));
  assign red      = reduce_op(op_e'(in_op), res_full, width_mask(WIDTH));
  assign res      = res_full[WIDTH-1:0];
  assign accept   = in_valid && in_ready;

  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      acc_d = res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    logic          up_v;
    logic [ZW-1:0] up_d;
    logic          dn_r;

    if (k == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = {red, res};
    end else begin : g_body
      assign up_v = stg_valid[k-1];
      assign up_d = stg_data[k-1];
    end

    if (k == int'(STAGES) - 1) begin : g_tail
      assign dn_r = out_ready;
    end else begin : g_link
      assign dn_r = stg_ready[k+1];
    end

    logic_gate_stage #(.DW(ZW)) u_stage (
      .clk          (clk),
      .rst_n        (rst_n),
      .up_valid_i   (up_v),
      .up_data_i    (up_d),
      .down_ready_i (dn_r),
      .ready_c_o    (stg_ready[k]),
      .valid_o      (stg_valid[k]),
      .data_o       (stg_data[k])
    );
  end

  assign in_ready  = stg_ready[0];
  assign out_valid = stg_valid[STAGES-1];
  assign z         = stg_data[STAGES-1];
  assign acc       = acc_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: scoreboard on a WIDTH=5/STAGES=2 instance plus
// latency and fill checks on WIDTH=1 instances with STAGES=1 and STAGES=4.
module tb_logic_gate_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       in_valid, in_ready, in_acc, in_clr, out_valid, out_ready;
  logic [2:0] in_op;
  logic [4:0] a, b, acc;
  logic [5:0] z;

  logic       s_in_valid [2];
  logic       s_in_ready [2];
  logic [2:0] s_op       [2];
  logic       s_a        [2];
  logic       s_b        [2];
  logic       s_out_valid[2];
  logic       s_out_ready[2];
  logic [1:0] s_z        [2];
  logic       s_acc      [2];

  typedef struct {
    logic [2:0] op;
    logic [4:0] a;
    logic [4:0] b;
    logic [5:0] exp;
  } vec_t;

  vec_t       vecs [10];
  logic [5:0] sb [$];
  logic [5:0] mon_exp;
  logic [4:0] model_acc;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(5), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_acc(in_acc), .in_clr(in_clr), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .acc(acc)
  );

  logic_gate_pipe #(.WIDTH(1), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid[0]), .in_ready(s_in_ready[0]),
    .in_op(s_op[0]), .in_acc(1'b0), .in_clr(1'b0), .a(s_a[0]), .b(s_b[0]),
    .out_valid(s_out_valid[0]), .out_ready(s_out_ready[0]), .z(s_z[0]), .acc(s_acc[0])
  );

  logic_gate_pipe #(.WIDTH(1), .STAGES(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid[1]), .in_ready(s_in_ready[1]),
    .in_op(s_op[1]), .in_acc(1'b0), .in_clr(1'b0), .a(s_a[1]), .b(s_b[1]),
    .out_valid(s_out_valid[1]), .out_ready(s_out_ready[1]), .z(s_z[1]), .acc(s_acc[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Independent reference for one WIDTH=5 beat: {reduction, result}.
  function automatic logic [5:0] model_z(input logic [2:0] op, input logic [4:0] x,
                                         input logic [4:0] y);
    logic [4:0] r;
    logic       rd;
    case (op)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: r = ~(x & y);
      3'd4: r = ~(x | y);
      3'd5: r = ~(x ^ y);
      3'd6: r = x;
      default: r = ~x;
    endcase
    if (op == 3'd0 || op == 3'd3) rd = &r;
    else if (op == 3'd1 || op == 3'd4) rd = |r;
    else rd = ^r;
    return {rd, r};
  endfunction

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_beat actual=%0h required=none at %0t", z, $time);
      end else begin
        mon_exp = sb.pop_front();
        chk("z_out", 64'(z), 64'(mon_exp));
      end
    end
  end

  // Called and returns just after a rising edge; holds the beat until accepted.
  task automatic send(input logic [2:0] op, input logic ac, input logic cl,
                      input logic [4:0] aa, input logic [4:0] bb,
                      input logic [5:0] exp, output int waits);
    in_op = op; in_acc = ac; in_clr = cl; a = aa; b = bb; in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp);
        model_acc = exp[4:0];
        @(posedge clk); #1;
        chk("acc_update", 64'(acc), 64'(model_acc));
        break;
      end
      @(posedge clk); #1;
      waits++;
      if (waits > 50) begin
        chk("accept_timeout", 64'(waits), 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_small(input int k);
    int         st, lat, nacc, nout;
    logic [1:0] sq [$];
    logic [1:0] e;
    logic       a1;
    st = (k == 0) ? 1 : 4;
    s_out_ready[k] = 1'b1; s_op[k] = 3'd1; s_a[k] = 1'b1; s_b[k] = 1'b0;
    s_in_valid[k] = 1'b1;
    @(negedge clk);
    chk("s_in_ready_idle", 64'(s_in_ready[k]), 64'd1);
    @(posedge clk); #1;
    s_in_valid[k] = 1'b0;
    lat = 1;
    while (!s_out_valid[k] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("s_latency", 64'(lat), 64'(st));
    chk("s_z_first", 64'(s_z[k]), 64'd3);
    @(posedge clk); #1;
    chk("s_emptied", 64'(s_out_valid[k]), 64'd0);

    s_out_ready[k] = 1'b0;
    nacc = 0;
    for (int c = 0; c < st + 2; c++) begin
      a1 = nacc[0];
      s_op[k] = 3'd7; s_a[k] = a1; s_in_valid[k] = 1'b1;
      @(negedge clk);
      if (s_in_ready[k]) begin
        sq.push_back({~a1, ~a1});
        nacc++;
      end
      @(posedge clk); #1;
    end
    chk("s_fill_accepts", 64'(nacc), 64'(st));
    chk("s_full_in_ready", 64'(s_in_ready[k]), 64'd0);

    s_in_valid[k] = 1'b0; s_out_ready[k] = 1'b1;
    nout = 0;
    for (int c = 0; c < st + 4; c++) begin
      @(negedge clk);
      if (s_out_valid[k]) begin
        nout++;
        if (sq.size() != 0) begin
          e = sq.pop_front();
          chk("s_z_order", 64'(s_z[k]), 64'(e));
        end
      end
      @(posedge clk); #1;
    end
    chk("s_out_count", 64'(nout), 64'(st));
  endtask

  initial begin
    int         waits, lat, nacc, spur;
    logic [2:0] rop;
    logic [4:0] ra, rb, bp_a;
    logic       rac, rcl;
    logic [5:0] z_hold;

    vecs[0] = '{3'd0, 5'b10110, 5'b11100, 6'b0_10100};
    vecs[1] = '{3'd1, 5'b10000, 5'b00001, 6'b1_10001};
    vecs[2] = '{3'd2, 5'b11001, 5'b01100, 6'b1_10101};
    vecs[3] = '{3'd3, 5'b11111, 5'b11111, 6'b0_00000};
    vecs[4] = '{3'd4, 5'b00000, 5'b00000, 6'b1_11111};
    vecs[5] = '{3'd5, 5'b01011, 5'b01011, 6'b1_11111};
    vecs[6] = '{3'd6, 5'b10110, 5'b11111, 6'b1_10110};
    vecs[7] = '{3'd7, 5'b10110, 5'b00000, 6'b0_01001};
    vecs[8] = '{3'd0, 5'b11111, 5'b11111, 6'b1_11111};
    vecs[9] = '{3'd4, 5'b00001, 5'b00000, 6'b1_11110};

    in_valid = 0; in_op = 0; in_acc = 0; in_clr = 0; a = 0; b = 0; out_ready = 1;
    model_acc = 0;
    for (int k = 0; k < 2; k++) begin
      s_in_valid[k] = 0; s_op[k] = 0; s_a[k] = 0; s_b[k] = 0; s_out_ready[k] = 1;
    end

    #2 rst_n = 1'b0;
    #10;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_z", 64'(z), 64'd0);
    chk("rst_acc", 64'(acc), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // First beat: latency of STAGES cycles with no stalls.
    send(vecs[0].op, 1'b0, 1'b0, vecs[0].a, vecs[0].b, vecs[0].exp, waits);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd2);
    drain();

    for (int i = 1; i < 10; i++) begin
      send(vecs[i].op, 1'b0, 1'b0, vecs[i].a, vecs[i].b, vecs[i].exp, waits);
    end
    drain();

    // Back-to-back random stream, every op, random accumulate/seed.
    for (int i = 0; i < 10; i++) begin
      rop = 3'(i);
      ra  = 5'($urandom);
      rb  = 5'($urandom);
      rac = 1'($urandom_range(0, 1));
      rcl = 1'($urandom_range(0, 1));
      send(rop, rac, rcl, ra, rb, model_z(rop, ra, (rac && !rcl) ? model_acc : rb), waits);
      chk("stream_no_wait", 64'(waits), 64'd0);
    end
    drain();

    // Accumulate XOR chain; the first beat has both in_acc and in_clr set.
    send(3'd2, 1'b1, 1'b1, 5'b00011, 5'b00001, 6'b1_00010, waits);
    send(3'd2, 1'b1, 1'b0, 5'b00100, 5'b11111, 6'b0_00110, waits);
    send(3'd2, 1'b1, 1'b0, 5'b01000, 5'b10101, 6'b1_01110, waits);
    drain();
    chk("acc_chain", 64'(acc), 64'b01110);

    // Backpressure: exactly STAGES accepts, z holds, then drain in order.
    out_ready = 1'b0;
    nacc = 0;
    z_hold = '0;
    for (int c = 0; c < 5; c++) begin
      bp_a = 5'(nacc + 1);
      in_op = 3'd6; in_acc = 0; in_clr = 0; a = bp_a; b = 5'b0; in_valid = 1'b1;
      @(negedge clk);
      if (c == 2) begin
        z_hold = z;
        chk("stall_z_head", 64'(z), 64'b1_00001);
      end
      if (c >= 2) chk("stall_out_valid", 64'(out_valid), 64'd1);
      if (c >= 3) chk("stall_z_hold", 64'(z), 64'(z_hold));
      if (in_ready) begin
        sb.push_back(model_z(3'd6, bp_a, 5'b0));
        model_acc = bp_a;
        nacc++;
      end else begin
        chk("stall_acc_hold", 64'(acc), 64'(model_acc));
      end
      @(posedge clk); #1;
    end
    chk("bp_accepts", 64'(nacc), 64'd2);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    if (in_ready) begin
      sb.push_back(model_z(3'd6, a, 5'b0));
      model_acc = a;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Async reset with two beats in flight.
    out_ready = 1'b0;
    send(3'd6, 1'b0, 1'b0, 5'b00000, 5'b00000, 6'b0_00000, waits);
    send(3'd6, 1'b0, 1'b0, 5'b10101, 5'b00000, 6'b1_10101, waits);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_z", 64'(z), 64'd0);
    chk("async_acc", 64'(acc), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    model_acc = '0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    spur = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) spur++;
    end
    chk("no_stale_beat", 64'(spur), 64'd0);
    @(posedge clk); #1;

    run_small(0);
    run_small(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
